// File: rtl/imm_narrow_pkg.sv
// imm_narrow_pkg: shared types and constants for the immediate-narrowing block.
//   - DATA_W / WIDTH_W : datapath width and width-counter width
//   - imm_state_e      : controller states (IMM_IDLE, IMM_SCAN, IMM_DONE)
//   - IMM_ZERO/IMM_SIGN: extension-mode encodings
//   - scan_ctx_t       : working context latched at accept and updated while scanning
//   - lead_redundant() : true when the current leading bit adds no information
package imm_narrow_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned WIDTH_W = 4;

  typedef enum logic [1:0] {
    IMM_IDLE = 2'd0,
    IMM_SCAN = 2'd1,
    IMM_DONE = 2'd2
  } imm_state_e;

  localparam logic IMM_ZERO = 1'b0;
  localparam logic IMM_SIGN = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]  sh;    // value shifted left as leading bits are dropped
    logic [DATA_W-1:0]  held;  // untouched copy used to build the field
    logic               mode;  // IMM_ZERO or IMM_SIGN
    logic [WIDTH_W-1:0] w;     // current candidate width
  } scan_ctx_t;

  // Zero mode: a leading 0 is redundant. Sign mode: a leading bit equal to
  // its neighbour is a redundant sign copy.
  function automatic logic lead_redundant(input logic [1:0] top, input logic mode);
    logic red;
    red = 1'b0;
    if (mode == IMM_SIGN) begin
      red = (top[1] == top[0]);
    end else begin
      red = ~top[1];
    end
    return red;
  endfunction

endpackage

// File: rtl/imm_narrow_lead_step.sv
// imm_narrow_lead_step: one leading-bit test of the narrowing scan.
// Ports:
//   i_sh_top : top two bits of the shift register
//   i_w      : current candidate width (1..8)
//   i_mode   : IMM_ZERO (zero-extension) or IMM_SIGN (sign-extension)
//   o_cont_c : 1 when the scan may drop another leading bit (combinational)
module imm_narrow_lead_step
  import imm_narrow_pkg::*;
(
  input  logic [1:0]         i_sh_top,
  input  logic [WIDTH_W-1:0] i_w,
  input  logic               i_mode,
  output logic               o_cont_c
);

  // Width 1 is the floor; never narrow past it.
  always_comb begin
    o_cont_c = 1'b0;
    if (i_w > WIDTH_W'(1)) begin
      o_cont_c = lead_redundant(i_sh_top, i_mode);
    end
  end

endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: finds the minimal zero- or sign-extended width of an 8-bit value,
// one leading bit per clock, and emits the N-bit instruction field.
// Optional build macro: IMM_NARROW_SAT_EN -- when the value does not fit,
// out_field saturates (unsigned: all ones; signed: max positive / min negative)
// instead of truncating. out_fits/out_width are identical in both builds.
// Ports:
//   clock, resetn           : clock, synchronous active-low reset
//   in_valid/in_ready       : input handshake (in_ready high only in IDLE)
//   in_data, in_signed      : value and extension mode, sampled at accept only
//   out_valid/out_ready     : output handshake, outputs held stable in DONE
//   out_field, out_fits     : N-bit field and fit flag (out_width <= N)
//   out_width               : minimal width 1..8 (0 after reset)
module imm_narrow
  import imm_narrow_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_field,
  output logic               out_fits,
  output logic [WIDTH_W-1:0] out_width
);

  imm_state_e         r_state;
  imm_state_e         w_state_nxt;
  scan_ctx_t          r_ctx;
  scan_ctx_t          w_ctx_nxt;
  logic               r_in_ready;
  logic               w_in_ready_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic [N-1:0]       r_out_field;
  logic [N-1:0]       w_out_field_nxt;
  logic               r_out_fits;
  logic               w_out_fits_nxt;
  logic [WIDTH_W-1:0] r_out_width;
  logic [WIDTH_W-1:0] w_out_width_nxt;

  logic               w_cont_c;
  logic               w_fits_c;
  logic [N-1:0]       w_field_c;
  logic               w_unused_held;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_field = r_out_field;
  assign out_fits  = r_out_fits;
  assign out_width = r_out_width;

  // Only the low field bits (and the sign bit when saturating) of the held copy matter.
  assign w_unused_held = ^r_ctx.held;

  // Leading-bit test for the current scan step.
  imm_narrow_lead_step u_lead_step (
    .i_sh_top (r_ctx.sh[DATA_W-1 -: 2]),
    .i_w      (r_ctx.w),
    .i_mode   (r_ctx.mode),
    .o_cont_c (w_cont_c)
  );

  assign w_fits_c = (r_ctx.w <= WIDTH_W'(N));

`ifdef IMM_NARROW_SAT_EN
  localparam logic [N-1:0] FIELD_ONES = '1;
  localparam logic [N-1:0] FIELD_SPOS = FIELD_ONES >> 1;
  localparam logic [N-1:0] FIELD_SNEG = ~FIELD_SPOS;

  // Saturate an out-of-range value toward the nearest representable extreme.
  always_comb begin
    w_field_c = r_ctx.held[N-1:0];
    if (!w_fits_c) begin
      if (r_ctx.mode == IMM_ZERO) begin
        w_field_c = FIELD_ONES;
      end else if (!r_ctx.held[DATA_W-1]) begin
        w_field_c = FIELD_SPOS;
      end else begin
        w_field_c = FIELD_SNEG;
      end
    end
  end
`else
  // Plain truncation to the field width.
  always_comb begin
    w_field_c = r_ctx.held[N-1:0];
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IMM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IMM_IDLE: if (in_valid)  w_state_nxt = IMM_SCAN;
      IMM_SCAN: if (!w_cont_c) w_state_nxt = IMM_DONE;
      IMM_DONE: if (out_ready) w_state_nxt = IMM_IDLE;
      default:                 w_state_nxt = IMM_IDLE;
    endcase
  end

  // Datapath and output next values; everything leaves the block registered.
  always_comb begin
    w_ctx_nxt       = r_ctx;
    w_out_valid_nxt = r_out_valid;
    w_out_field_nxt = r_out_field;
    w_out_fits_nxt  = r_out_fits;
    w_out_width_nxt = r_out_width;
    w_in_ready_nxt  = (w_state_nxt == IMM_IDLE);
    case (r_state)
      IMM_IDLE: begin
        if (in_valid) begin
          w_ctx_nxt.sh   = in_data;
          w_ctx_nxt.held = in_data;
          w_ctx_nxt.mode = in_signed;
          w_ctx_nxt.w    = WIDTH_W'(DATA_W);
        end
      end
      IMM_SCAN: begin
        if (w_cont_c) begin
          w_ctx_nxt.sh = {r_ctx.sh[DATA_W-2:0], 1'b0};
          w_ctx_nxt.w  = r_ctx.w - WIDTH_W'(1);
        end else begin
          w_out_width_nxt = r_ctx.w;
          w_out_fits_nxt  = w_fits_c;
          w_out_field_nxt = w_field_c;
          w_out_valid_nxt = 1'b1;
        end
      end
      IMM_DONE: begin
        // Result data stays on the bus after the handshake; only valid drops.
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ctx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_field <= '0;
      r_out_fits  <= 1'b0;
      r_out_width <= '0;
    end else begin
      r_ctx       <= w_ctx_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_field <= w_out_field_nxt;
      r_out_fits  <= w_out_fits_nxt;
      r_out_width <= w_out_width_nxt;
    end
  end

endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: self-checking bench for imm_narrow with N=3. Directed vector
// table, handshake/reset corner sequences, then random values against a
// range-based width model. Honours IMM_NARROW_SAT_EN for the expected field.
module tb_imm_narrow;

  localparam int unsigned N = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_signed = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [N-1:0] out_field;
  logic       out_fits;
  logic [3:0] out_width;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  imm_narrow #(.N(N)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_fits  (out_fits),
    .out_width (out_width)
  );

  typedef struct {
    logic [7:0]   data;
    logic         sgn;
    int           lat;
    logic [3:0]   width;
    logic         fits;
    logic [N-1:0] f_trunc;
    logic [N-1:0] f_sat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: smallest width whose representable range contains the value.
  function automatic void model(input logic [7:0] d, input logic s,
                                output int w, output logic [N-1:0] f);
    int v;
    if (s) begin
      v = int'($signed(d));
      w = 1;
      while (w < 8 && (v < -(1 << (w - 1)) || v > (1 << (w - 1)) - 1)) w++;
    end else begin
      v = int'(d);
      w = 1;
      while (w < 8 && v >= (1 << w)) w++;
    end
    f = d[N-1:0];
`ifdef IMM_NARROW_SAT_EN
    if (w > int'(N)) begin
      if (!s)          f = N'((1 << N) - 1);
      else if (v >= 0) f = N'((1 << (N - 1)) - 1);
      else             f = N'(1 << (N - 1));
    end
`endif
  endfunction

  // Present one value, measure accept-to-valid latency, check the result.
  task automatic do_txn(input logic [7:0] d, input logic s, input int exp_lat,
                        input logic [3:0] exp_w, input logic exp_fits,
                        input logic [N-1:0] exp_f, input bit release_out,
                        input string tag);
    int cyc;
    @(negedge clock);
    chk({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    in_signed = 1'($urandom);
    chk({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_width"}, 32'(out_width), 32'(exp_w));
    chk({tag, "_fits"}, 32'(out_fits), 32'(exp_fits));
    chk({tag, "_field"}, 32'(out_field), 32'(exp_f));
    if (release_out) begin
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
      chk({tag, "_width_kept"}, 32'(out_width), 32'(exp_w));
    end
  endtask

  initial begin
    int w;
    logic [N-1:0] f;
    logic [7:0] d;
    logic s;

    //           data   sgn lat width fits trunc   sat
    vecs.push_back('{8'h05, 1'b0, 6, 4'd3, 1'b1, 3'b101, 3'b101});
    vecs.push_back('{8'hFD, 1'b1, 6, 4'd3, 1'b1, 3'b101, 3'b101});
    vecs.push_back('{8'h00, 1'b0, 8, 4'd1, 1'b1, 3'b000, 3'b000});
    vecs.push_back('{8'h00, 1'b1, 8, 4'd1, 1'b1, 3'b000, 3'b000});
    vecs.push_back('{8'hFF, 1'b1, 8, 4'd1, 1'b1, 3'b111, 3'b111});
    vecs.push_back('{8'h7F, 1'b1, 1, 4'd8, 1'b0, 3'b111, 3'b011});
    vecs.push_back('{8'h80, 1'b1, 1, 4'd8, 1'b0, 3'b000, 3'b100});
    vecs.push_back('{8'h80, 1'b0, 1, 4'd8, 1'b0, 3'b000, 3'b111});
    vecs.push_back('{8'hFF, 1'b0, 1, 4'd8, 1'b0, 3'b111, 3'b111});
    vecs.push_back('{8'h08, 1'b0, 5, 4'd4, 1'b0, 3'b000, 3'b111});
    vecs.push_back('{8'h07, 1'b0, 6, 4'd3, 1'b1, 3'b111, 3'b111});
    vecs.push_back('{8'h04, 1'b1, 5, 4'd4, 1'b0, 3'b100, 3'b011});
    vecs.push_back('{8'hFC, 1'b1, 6, 4'd3, 1'b1, 3'b100, 3'b100});
    vecs.push_back('{8'h01, 1'b0, 8, 4'd1, 1'b1, 3'b001, 3'b001});

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_width", 32'(out_width), 32'd0);
    chk("rst_out_fits", 32'(out_fits), 32'd0);
    chk("rst_out_field", 32'(out_field), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
`ifdef IMM_NARROW_SAT_EN
      f = vecs[i].f_sat;
`else
      f = vecs[i].f_trunc;
`endif
      do_txn(vecs[i].data, vecs[i].sgn, vecs[i].lat, vecs[i].width,
             vecs[i].fits, f, 1'b1, $sformatf("vec%0d", i));
    end

    // Backpressure: DONE holds for 5 cycles, producer pushes 0x01 meanwhile
    do_txn(8'h05, 1'b0, 6, 4'd3, 1'b1, 3'b101, 1'b0, "bp");
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_width", 32'(out_width), 32'd3);
      chk("bp_hold_field", 32'(out_field), 32'd5);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    chk("bp_no_accept", 32'(in_ready), 32'd1);

    // Reset on the third SCAN cycle of 0x00
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 8'h00;
    in_signed = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rs_scanning", 32'(in_ready), 32'd0);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_width", 32'(out_width), 32'd0);
    chk("rs_out_field", 32'(out_field), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    do_txn(8'h05, 1'b0, 6, 4'd3, 1'b1, 3'b101, 1'b1, "rs_fresh");

    // Reset beats a simultaneous in_valid
    @(negedge clock);
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    in_signed = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    resetn   = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("rv_not_latched", 32'(in_ready), 32'd1);
    chk("rv_no_valid", 32'(out_valid), 32'd0);

    // Random values against the model
    for (int i = 0; i < 150; i++) begin
      d = 8'($urandom);
      s = 1'($urandom);
      model(d, s, w, f);
      do_txn(d, s, 9 - w, 4'(w), 1'(w <= int'(N)), f, 1'b1,
             $sformatf("rnd%0d_%02h_%0d", i, d, s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_narrow.md
Name: imm_narrow

Overview:
- Reverse of the 8-bit immediate extenders: takes an 8-bit datapath value and finds the minimal field width that represents it, zero-extended or sign-extended.
- Reports whether the value fits an N-bit instruction field and emits that field.
- Iterative: one leading-bit test per clock, valid/ready on both sides.
- Used by the assembler-assist / immediate-encode path of the multicycle processor.

Parameters:
- N, 3, target field width in bits; legal range 1..7.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous reset, active-low
- in_valid  in  1  input value present
- in_ready  out  1  block can accept a value (high only in IDLE)
- in_data  in  8  value to narrow
- in_signed  in  1  1 = sign-extension semantics, 0 = zero-extension semantics
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_field  out  N  N-bit field for the instruction
- out_fits  out  1  1 if out_width <= N
- out_width  out  4  minimal width, 1..8

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous, active-low (resetn sampled on the clock edge).
  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_field=0, out_fits=0, out_width=0, shift reg=0, width counter=0.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into shift reg sh and a held copy, latch in_signed, width counter w=8, then go to SCAN.
- SCAN (in_ready=0): each cycle evaluates one step.
  - Unsigned mode: if w>1 and sh[7]==0, then sh<<=1 and w--. Otherwise stop.
  - Signed mode: if w>1 and sh[7]==sh[6], then sh<<=1 and w--. Otherwise stop.
  - On stop, on the same edge:
    - out_width=w
    - out_fits=(w<=N)
    - out_field=held[N-1:0]
    - out_valid=1, go to DONE.
  - SCAN lasts (8-w_final)+1 cycles, 1..8.
  - Latency from the accept edge to out_valid high is that many cycles.
- DONE:
  - out_valid=1 and all outputs held stable until out_ready.
  - On the out_valid&&out_ready edge: out_valid=0, go to IDLE.
  - Output data registers keep their last value after the handshake.
- Boundary values:
  - Zero gives width 1 in both modes.
  - Signed 0xFF gives width 1.
  - Unsigned 0x80 and signed 0x7F/0x80 give width 8 after a single SCAN cycle.
- No overlap: a new input is never accepted while SCAN or DONE is active. in_valid in those states is ignored, and the producer keeps it asserted.
- Simultaneous in_valid and resetn=0: reset wins and the input is not latched.
- Reset mid-SCAN or in DONE: the next state is IDLE with reset values, and the pending result is discarded.
- in_data and in_signed are sampled only at the accept edge.

Optional Feature:
- Macro: IMM_NARROW_SAT_EN
- Defined: when out_fits=0, out_field saturates instead of truncating.
  - Unsigned: all ones.
  - Signed, held[7]=0: {0,1..1}.
  - Signed, held[7]=1: {1,0..0}.
- Undefined: out_field is always held[N-1:0] (plain truncation).
- out_fits and out_width are identical in both builds.

Decomposition:
- Shared include imm_defs.vh holds:
  - state encodings IMM_IDLE=2'd0, IMM_SCAN=2'd1, IMM_DONE=2'd2
  - mode constants IMM_ZERO=1'b0, IMM_SIGN=1'b1
- One natural sub-module, lead_step:
  - Combinational.
  - Inputs: sh[7:6], w, mode.
  - Outputs: continue flag.
- Saturation logic stays inline under the macro.

Test Plan (N=3):
- Unsigned 0x05 accepted: out_valid rises 6 cycles after accept; out_width=3, out_fits=1, out_field=3'b101.
- Signed 0xFD (-3): 6 SCAN cycles; out_width=3, out_fits=1, out_field=3'b101.
- Unsigned 0x00: 8 SCAN cycles; out_width=1, out_fits=1, out_field=3'b000.
- Signed 0x7F: 1 SCAN cycle; out_width=8, out_fits=0.
  - out_field=3'b111 without the macro.
  - out_field=3'b011 with IMM_NARROW_SAT_EN.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE, then in_valid pulsed with 0x01.
  - Required: outputs unchanged, in_ready=0, no accept.
  - After out_ready=1: IDLE next cycle, in_ready=1.
- Reset during SCAN:
  - Stimulus: resetn=0 on cycle 3 of scanning 0x00.
  - Required: next cycle state IDLE, out_valid=0, out_width=0, in_ready=1.
  - After release, a fresh 0x05 gives the same result as the first scenario.
